snow64_ext_mem_arbiter: RTL and testbench

- Shares the CPU's single external memory access port between two requesters: requester 0 is instruction fetch, requester 1 is the data LAR file.
- Each requester issues whole-line (LarData-wide) reads or writes through a req/busy handshake.
- The arbiter queues at most one pending request per requester, grants round-robin and sequences exactly one external transaction at a time.
- Sits between the fetch/LAR-file logic and the ext_dat_acc_mem fields of the CPU's external ports.

---
 rtl/snow64_ext_mem_arbiter_pkg.sv | 36 +++
 rtl/snow64_ext_mem_arbiter_rr.sv | 15 +
 rtl/snow64_ext_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_snow64_ext_mem_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snow64_ext_mem_arbiter_pkg.sv
// snow64_ext_mem_arbiter_pkg: shared types for the external memory arbiter.
// Provides CpuAddr/LarData widths, the external access type, the arbiter
// state enum and the per-requester partial port structs.
package snow64_ext_mem_arbiter_pkg;

    localparam int ADDR_WIDTH = 64;
    localparam int DATA_WIDTH = 256;

    typedef logic [ADDR_WIDTH-1:0] CpuAddr;
    typedef logic [DATA_WIDTH-1:0] LarData;

    typedef enum logic {
        ExtRead  = 1'b0,
        ExtWrite = 1'b1
    } ExtDataAccessType;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } ExtMemArbState;

    typedef struct packed {
        logic             req;
        ExtDataAccessType accessType;
        CpuAddr           addr;
        LarData           data;
    } PartialPortIn_ExtMemArb_Rqr;

    typedef struct packed {
        logic   busy;
        LarData data;
    } PartialPortOut_ExtMemArb_Rqr;

endpackage

// File: rtl/snow64_ext_mem_arbiter_rr.sv
// snow64_rr_arbiter_2: combinational two-way round-robin picker.
// Ports: pending[1:0] requesters with work queued, lastGrant most recently
// served requester; grant chosen requester, valid high when any is pending.
module snow64_rr_arbiter_2 (
    input  logic [1:0] pending,
    input  logic       lastGrant,
    output logic       grant,
    output logic       valid
);

    assign valid = |pending;
    // On a tie the requester that was not served last wins.
    assign grant = (&pending) ? ~lastGrant : pending[1];

endmodule

// File: rtl/snow64_ext_mem_arbiter.sv
// snow64_ext_mem_arbiter: shares one external memory port between two requesters.
// Ports: clk/rst_n (async active-low); per requester N: in_rqrN_req/access_type/
// addr/data request fields, out_rqrN_busy and out_rqrN_data (last read line);
// external side: out_ext_req pulse with out_ext_access_type/addr/data held until
// completion, in_ext_busy/in_ext_data from memory; out_grant_id current owner.
module snow64_ext_mem_arbiter
    import snow64_ext_mem_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_rqr0_req,
    input  logic                  in_rqr0_access_type,
    input  logic [ADDR_WIDTH-1:0] in_rqr0_addr,
    input  logic [DATA_WIDTH-1:0] in_rqr0_data,
    output logic                  out_rqr0_busy,
    output logic [DATA_WIDTH-1:0] out_rqr0_data,
    input  logic                  in_rqr1_req,
    input  logic                  in_rqr1_access_type,
    input  logic [ADDR_WIDTH-1:0] in_rqr1_addr,
    input  logic [DATA_WIDTH-1:0] in_rqr1_data,
    output logic                  out_rqr1_busy,
    output logic [DATA_WIDTH-1:0] out_rqr1_data,
    output logic                  out_ext_req,
    output logic                  out_ext_access_type,
    output logic [ADDR_WIDTH-1:0] out_ext_addr,
    output logic [DATA_WIDTH-1:0] out_ext_data,
    input  logic                  in_ext_busy,
    input  logic [DATA_WIDTH-1:0] in_ext_data,
    output logic                  out_grant_id
);

    PartialPortIn_ExtMemArb_Rqr  inRqr [2];
    // The req field of a slot doubles as its pending flag and the requester's busy.
    PartialPortIn_ExtMemArb_Rqr  slot  [2];
    PartialPortOut_ExtMemArb_Rqr rqrOut[2];
    LarData                      rqrData[2];
    ExtMemArbState               state;
    ExtDataAccessType            extAccessType;
    CpuAddr                      extAddr;
    LarData                      extData;
    logic                        extReq;
    logic                        grantId;
    logic                        lastGrant;
    logic [1:0]                  pending;
    logic [1:0]                  pickPending;
    logic                        pickGrant;
    logic                        pickValid;

    assign inRqr[0] = '{req: in_rqr0_req, accessType: ExtDataAccessType'(in_rqr0_access_type),
                        addr: in_rqr0_addr, data: in_rqr0_data};
    assign inRqr[1] = '{req: in_rqr1_req, accessType: ExtDataAccessType'(in_rqr1_access_type),
                        addr: in_rqr1_addr, data: in_rqr1_data};

    assign pending = {slot[1].req, slot[0].req};
    // While finishing, the owner's slot is still set but must not be re-picked.
    assign pickPending = (state == WAIT_DONE) ? (pending & ~(2'b01 << grantId)) : pending;

    snow64_rr_arbiter_2 rrArbiter (
        .pending  (pickPending),
        .lastGrant(lastGrant),
        .grant    (pickGrant),
        .valid    (pickValid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                slot[i]    <= '0;
                rqrData[i] <= '0;
            end
            state         <= IDLE;
            extReq        <= 1'b0;
            extAccessType <= ExtRead;
            extAddr       <= '0;
            extData       <= '0;
            grantId       <= 1'b0;
            lastGrant     <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++)
                if (inRqr[i].req && !slot[i].req)
                    slot[i] <= inRqr[i];
            case (state)
                IDLE: begin
                    if (pickValid) begin
                        extAccessType <= slot[pickGrant].accessType;
                        extAddr       <= slot[pickGrant].addr;
                        extData       <= slot[pickGrant].data;
                        grantId       <= pickGrant;
                        extReq        <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    extReq <= 1'b0;
                    state  <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (in_ext_busy)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!in_ext_busy) begin
                        if (slot[grantId].accessType == ExtRead)
                            rqrData[grantId] <= in_ext_data;
                        slot[grantId].req <= 1'b0;
                        lastGrant         <= grantId;
                        if (pickValid) begin
                            extAccessType <= slot[pickGrant].accessType;
                            extAddr       <= slot[pickGrant].addr;
                            extData       <= slot[pickGrant].data;
                            grantId       <= pickGrant;
                            extReq        <= 1'b1;
                            state         <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rqrOut[0] = '{busy: slot[0].req, data: rqrData[0]};
    assign rqrOut[1] = '{busy: slot[1].req, data: rqrData[1]};

    assign out_rqr0_busy       = rqrOut[0].busy;
    assign out_rqr0_data       = rqrOut[0].data;
    assign out_rqr1_busy       = rqrOut[1].busy;
    assign out_rqr1_data       = rqrOut[1].data;
    assign out_ext_req         = extReq;
    assign out_ext_access_type = extAccessType;
    assign out_ext_addr        = extAddr;
    assign out_ext_data        = extData;
    assign out_grant_id        = grantId;

endmodule

// File: tb/tb_snow64_ext_mem_arbiter.sv
// tb_snow64_ext_mem_arbiter: randomized self-checking bench with a transaction-level model.
module tb_snow64_ext_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, type0 = 1'b0, req1 = 1'b0, type1 = 1'b0;
    logic [63:0]  addr0 = '0, addr1 = '0;
    logic [255:0] wdata0 = '0, wdata1 = '0;
    logic         busy0, busy1;
    logic [255:0] data0, data1;
    logic         extReq, extType, grantId;
    logic [63:0]  extAddr;
    logic [255:0] extDataOut;
    logic         extBusy = 1'b0;
    logic [255:0] extIn = '0;

    snow64_ext_mem_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_rqr0_req        (req0),
        .in_rqr0_access_type(type0),
        .in_rqr0_addr       (addr0),
        .in_rqr0_data       (wdata0),
        .out_rqr0_busy      (busy0),
        .out_rqr0_data      (data0),
        .in_rqr1_req        (req1),
        .in_rqr1_access_type(type1),
        .in_rqr1_addr       (addr1),
        .in_rqr1_data       (wdata1),
        .out_rqr1_busy      (busy1),
        .out_rqr1_data      (data1),
        .out_ext_req        (extReq),
        .out_ext_access_type(extType),
        .out_ext_addr       (extAddr),
        .out_ext_data       (extDataOut),
        .in_ext_busy        (extBusy),
        .in_ext_data        (extIn),
        .out_grant_id       (grantId)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           typ;
        logic [63:0]  addr;
        logic [255:0] data;
    } SlotT;

    int           cyc, nChecks, nFail, ignoredReqs;
    bit           mBusy[2];
    logic [255:0] mData[2];
    bit           mGrant, lastG, expPulse;
    int           inflight;
    SlotT         slot[2];
    bit           qReq[2], qType[2];
    logic [63:0]  qAddr[2];
    logic [255:0] qData[2];
    bit           rActive, fDataEn;
    int           rDelay, rLen, fDelay, fLen;
    logic [255:0] fData;
    int           pulses;
    int           pulseCyc[$], pulseGnt[$], pulseType[$];
    logic [63:0]  pulseAddr[$];
    int           busyFall[2], busyRise[2];
    bit           prevBusy[2];

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic setReq(input int i, input bit t, input logic [63:0] a, input logic [255:0] d);
        qReq[i] = 1'b1; qType[i] = t; qAddr[i] = a; qData[i] = d;
    endtask

    // One clock: check cycle outputs against the model, drive this cycle's inputs, advance the model.
    task automatic step();
        bit done;
        bit w[2], acc[2];
        bit ob[2];
        int comp;
        @(negedge clk);
        cyc++;
        chk("busy0", busy0, mBusy[0]);
        chk("busy1", busy1, mBusy[1]);
        chk("data0", data0, mData[0]);
        chk("data1", data1, mData[1]);
        chk("ext_req", extReq, expPulse);
        chk("grant_id", grantId, mGrant);
        if (inflight >= 0) begin
            chk("ext_type", extType, slot[inflight].typ);
            chk("ext_addr", extAddr, slot[inflight].addr);
            chk("ext_data", extDataOut, slot[inflight].data);
        end
        if (extReq) begin
            pulses++;
            pulseCyc.push_back(cyc);
            pulseGnt.push_back(int'(grantId));
            pulseType.push_back(int'(extType));
            pulseAddr.push_back(extAddr);
        end
        ob[0] = busy0; ob[1] = busy1;
        for (int i = 0; i < 2; i++) begin
            if (prevBusy[i] && !ob[i]) busyFall[i] = cyc;
            if (!prevBusy[i] && ob[i]) busyRise[i] = cyc;
            prevBusy[i] = ob[i];
        end
        // external memory responder
        done = 1'b0;
        extIn = rand256();
        if (rActive) begin
            if (rDelay > 0) begin extBusy = 1'b0; rDelay--; end
            else if (rLen > 0) begin extBusy = 1'b1; rLen--; end
            else begin
                extBusy = 1'b0; done = 1'b1; rActive = 1'b0;
                if (fDataEn) extIn = fData;
            end
        end else extBusy = 1'b0;
        if (extReq) begin
            rActive = 1'b1;
            rDelay = (fDelay >= 0) ? fDelay : int'($urandom_range(0, 2));
            rLen = (fLen > 0) ? fLen : int'($urandom_range(1, 4));
        end
        // requesters
        for (int i = 0; i < 2; i++) begin
            acc[i] = qReq[i] && !mBusy[i];
            if (qReq[i] && mBusy[i]) ignoredReqs++;
            if (acc[i]) slot[i] = '{typ: qType[i], addr: qAddr[i], data: qData[i]};
        end
        req0 = qReq[0]; type0 = qReq[0] ? qType[0] : 1'($urandom);
        addr0 = qReq[0] ? qAddr[0] : {$urandom, $urandom};
        wdata0 = qReq[0] ? qData[0] : rand256();
        req1 = qReq[1]; type1 = qReq[1] ? qType[1] : 1'($urandom);
        addr1 = qReq[1] ? qAddr[1] : {$urandom, $urandom};
        wdata1 = qReq[1] ? qData[1] : rand256();
        // model advance: waiting requesters, completion, next grant
        for (int i = 0; i < 2; i++) w[i] = mBusy[i] && (inflight != i);
        comp = -1;
        if (done && inflight >= 0) begin
            comp = inflight;
            if (!slot[comp].typ) mData[comp] = extIn;
            lastG = comp[0];
            inflight = -1;
        end
        for (int i = 0; i < 2; i++) mBusy[i] = acc[i] ? 1'b1 : ((comp == i) ? 1'b0 : mBusy[i]);
        if (inflight < 0 && (w[0] || w[1])) begin
            inflight = (w[0] && w[1]) ? int'(!lastG) : int'(w[1]);
            mGrant = inflight[0];
            expPulse = 1'b1;
        end else expPulse = 1'b0;
        qReq[0] = 1'b0; qReq[1] = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy0", busy0, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_data0", data0, 0);
        chk("rst_data1", data1, 0);
        chk("rst_ext_req", extReq, 0);
        chk("rst_ext_type", extType, 0);
        chk("rst_ext_addr", extAddr, 0);
        chk("rst_ext_data", extDataOut, 0);
        chk("rst_grant", grantId, 0);
        for (int i = 0; i < 2; i++) begin
            mBusy[i] = 1'b0; mData[i] = '0; qReq[i] = 1'b0; prevBusy[i] = 1'b0;
            busyFall[i] = -1; busyRise[i] = -1;
        end
        mGrant = 1'b0; lastG = 1'b0; expPulse = 1'b0; inflight = -1;
        rActive = 1'b0; fDelay = -1; fLen = -1; fDataEn = 1'b0;
        extBusy = 1'b0; req0 = 1'b0; req1 = 1'b0;
        pulses = 0;
        pulseCyc.delete(); pulseGnt.delete(); pulseType.delete(); pulseAddr.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = -1;
    endtask

    task automatic runIdle(input int maxc);
        int n;
        n = 0;
        while ((mBusy[0] || mBusy[1] || inflight >= 0 || expPulse) && n < maxc) begin
            step();
            n++;
        end
        nChecks++;
        if (n >= maxc) begin
            nFail++;
            $display("FAIL idle_timeout cyc=%0d actual=%0d cycles required<%0d", cyc, n, maxc);
        end
        step();
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        nChecks = 0; nFail = 0; ignoredReqs = 0; cyc = -1;

        // single read with literal timing
        doReset();
        fDelay = 0; fLen = 3; fDataEn = 1'b1; fData = {32{8'hAA}};
        setReq(0, 1'b0, 64'h1000, rand256());
        step();
        runIdle(50);
        chk("t1_pulses", pulses, 1);
        chk("t1_pulse_cyc", pulseCyc.size() > 0 ? pulseCyc[0] : -1, 2);
        chk("t1_pulse_addr", pulseAddr.size() > 0 ? pulseAddr[0] : '1, 64'h1000);
        chk("t1_busy_rise", busyRise[0], 1);
        chk("t1_busy_fall", busyFall[0], 7);
        chk("t1_data0", data0, {32{8'hAA}});

        // simultaneous requests after reset: requester 1 first
        doReset();
        setReq(0, 1'b0, 64'h40, rand256());
        setReq(1, 1'b1, 64'h80, {32{8'h55}});
        step();
        runIdle(80);
        chk("t2_pulses", pulses, 2);
        chk("t2_first_gnt", pulseGnt.size() > 0 ? pulseGnt[0] : -1, 1);
        chk("t2_first_type", pulseType.size() > 0 ? pulseType[0] : -1, 1);
        chk("t2_first_addr", pulseAddr.size() > 0 ? pulseAddr[0] : '1, 64'h80);
        chk("t2_second_gnt", pulseGnt.size() > 1 ? pulseGnt[1] : -1, 0);
        chk("t2_second_addr", pulseAddr.size() > 1 ? pulseAddr[1] : '1, 64'h40);
        chk("t2_data1", data1, 0);

        // fairness under constant re-requests
        doReset();
        n = 0;
        while (pulses < 6 && n < 300) begin
            for (int i = 0; i < 2; i++)
                if (!mBusy[i]) setReq(i, 1'($urandom), {$urandom, $urandom}, rand256());
            step();
            n++;
        end
        runIdle(80);
        for (int k = 0; k < 6; k++)
            chk($sformatf("t3_gnt%0d", k), pulseGnt.size() > k ? pulseGnt[k] : -1, (k % 2 == 0) ? 1 : 0);

        // request queued while the other is finishing
        doReset();
        fDelay = 0; fLen = 4;
        setReq(0, 1'b0, 64'h2000, rand256());
        step();
        repeat (3) step();
        setReq(1, 1'b0, 64'h3000, rand256());
        step();
        runIdle(80);
        chk("t4_busy1_rise", busyRise[1], 5);
        chk("t4_busy0_fall", busyFall[0], 8);
        chk("t4_pulse1_cyc", pulseCyc.size() > 1 ? pulseCyc[1] : -1, 8);
        chk("t4_pulse1_gnt", pulseGnt.size() > 1 ? pulseGnt[1] : -1, 1);

        // requests while busy are ignored
        doReset();
        setReq(0, 1'b0, 64'h4000, rand256());
        step();
        step();
        setReq(0, 1'b1, 64'h5000, rand256());
        step();
        setReq(0, 1'b1, 64'h6000, rand256());
        step();
        runIdle(80);
        chk("t5_pulses", pulses, 1);
        chk("t5_type", pulseType.size() > 0 ? pulseType[0] : -1, 0);

        // reset during WAIT_DONE, then normal operation
        doReset();
        fDelay = 0; fLen = 6;
        setReq(0, 1'b0, 64'h7000, rand256());
        step();
        while (cyc < 5) step();
        doReset();
        setReq(0, 1'b0, 64'h7100, rand256());
        step();
        runIdle(80);
        setReq(0, 1'b0, 64'h7200, rand256());
        setReq(1, 1'b0, 64'h7300, rand256());
        step();
        runIdle(80);
        chk("t6_pulses", pulses, 3);
        chk("t6_gnt0", pulseGnt.size() > 0 ? pulseGnt[0] : -1, 0);
        chk("t6_gnt1", pulseGnt.size() > 1 ? pulseGnt[1] : -1, 1);
        chk("t6_gnt2", pulseGnt.size() > 2 ? pulseGnt[2] : -1, 0);

        // randomized traffic
        doReset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 2; i++)
                if ($urandom_range(0, 2) == 0) setReq(i, 1'($urandom), {$urandom, $urandom}, rand256());
            step();
        end
        runIdle(100);

        $display("note: %0d requests issued while busy were ignored", ignoredReqs);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
